// File: rtl/inst_prefetch_buf_if.sv
// Instruction-memory port between the prefetch buffer (master) and memory (slave).
// Requests use a valid/ready handshake; responses are in order and always accepted.
interface inst_prefetch_buf_if;
    logic        imem_req_vld;
    logic        imem_req_rdy;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_vld;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_vld,
        output imem_req_addr,
        input  imem_req_rdy,
        input  imem_rsp_vld,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_vld,
        input  imem_req_addr,
        output imem_req_rdy,
        output imem_rsp_vld,
        output imem_rsp_data
    );
endinterface

// File: rtl/inst_prefetch_buf.sv
// Decoupled RV32 instruction-fetch front end: credit-limited requests, in-order
// prefetch FIFO feeding decode, and jump redirect that squashes in-flight responses.
module inst_prefetch_buf #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     asrst_n,
    input  logic                     hold,
    input  logic                     jmp_vld,
    input  logic [31:0]              jmp_addr,
    inst_prefetch_buf_if.master      imem,
    output logic                     IF_vld,
    output logic [31:0]              IF_pc,
    output logic [31:0]              IF_inst,
    output logic [$clog2(DEPTH):0]   IF_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] level;
    logic [AW-1:0] pcq_wr;
    logic [AW-1:0] pcq_rd;
    logic [AW-1:0] fifo_wr;
    logic [AW-1:0] fifo_rd;
    logic [31:0]   pcq_mem  [DEPTH];
    fetch_entry_t  fifo_mem [DEPTH];

    logic credit_ok;
    logic req_fire;
    logic rsp_fire;
    logic push;
    logic pop;

    // Credits cover both in-flight requests and already-buffered entries, so a push never finds the FIFO full.
    always_comb begin
        credit_ok          = ((CW+1)'(outstanding) + (CW+1)'(level)) < (CW+1)'(DEPTH);
        imem.imem_req_vld  = asrst_n && !jmp_vld && credit_ok;
        imem.imem_req_addr = fetch_pc;
        req_fire           = imem.imem_req_vld && imem.imem_req_rdy;
        rsp_fire           = imem.imem_rsp_vld;
        push               = rsp_fire && (drop_cnt == '0) && !jmp_vld;
        pop                = IF_vld && !hold && !jmp_vld;
    end

    // Show-ahead head of the FIFO; NOP is presented while empty.
    always_comb begin
        IF_vld   = (level != '0);
        IF_pc    = 32'h0;
        IF_inst  = NOP_INST;
        IF_level = level;
        if (IF_vld) begin
            IF_pc   = fifo_mem[fifo_rd].pc;
            IF_inst = fifo_mem[fifo_rd].inst;
        end
    end

    always_ff @(posedge clk or negedge asrst_n) begin
        if (!asrst_n) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            level       <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
        end else begin
            if (jmp_vld) begin
                fetch_pc <= jmp_addr & 32'hFFFF_FFFC;
            end else if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            if (req_fire) pcq_wr <= pcq_wr + AW'(1);
            if (rsp_fire) pcq_rd <= pcq_rd + AW'(1);

            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);

            // A response in the jump cycle is itself squashed, so it is not counted again.
            if (jmp_vld) begin
                drop_cnt <= outstanding - CW'(rsp_fire);
            end else if (rsp_fire && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end

            if (jmp_vld) begin
                fifo_wr <= '0;
                fifo_rd <= '0;
                level   <= '0;
            end else begin
                if (push) fifo_wr <= fifo_wr + AW'(1);
                if (pop)  fifo_rd <= fifo_rd + AW'(1);
                level <= level + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage arrays need no reset: contents are only visible behind valid pointers.
    always_ff @(posedge clk) begin
        if (req_fire) pcq_mem[pcq_wr] <= fetch_pc;
        if (push)     fifo_mem[fifo_wr] <= '{pc: pcq_mem[pcq_rd], inst: imem.imem_rsp_data};
    end

endmodule

// File: tb/tb_inst_prefetch_buf.sv
// Directed bench for inst_prefetch_buf with a fixed-latency in-order memory model.
module tb_inst_prefetch_buf;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        asrst_n;
    logic        hold;
    logic        jmp_vld;
    logic [31:0] jmp_addr;
    logic        IF_vld;
    logic [31:0] IF_pc;
    logic [31:0] IF_inst;
    logic [2:0]  IF_level;

    inst_prefetch_buf_if imem_bus ();

    inst_prefetch_buf #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk      (clk),
        .asrst_n  (asrst_n),
        .hold     (hold),
        .jmp_vld  (jmp_vld),
        .jmp_addr (jmp_addr),
        .imem     (imem_bus),
        .IF_vld   (IF_vld),
        .IF_pc    (IF_pc),
        .IF_inst  (IF_inst),
        .IF_level (IF_level)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    mem_req_t mq[$];
    int cyc;
    int lat;
    int hs_cnt;
    int errors;
    int checks;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A00_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present the head response once its latency has elapsed.
    task automatic mem_drive();
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_bus.imem_rsp_vld  = 1'b1;
            imem_bus.imem_rsp_data = inst_of(mq[0].addr);
        end else begin
            imem_bus.imem_rsp_vld  = 1'b0;
            imem_bus.imem_rsp_data = 32'h0;
        end
    endtask

    // One clock: sample the handshakes just before the edge, return 1 time unit after it.
    task automatic cycle();
        @(negedge clk);
        #3;
        if (imem_bus.imem_rsp_vld) mq.delete(0);
        if (imem_bus.imem_req_vld && imem_bus.imem_req_rdy) begin
            mq.push_back('{addr: imem_bus.imem_req_addr, due: cyc + lat});
            hs_cnt++;
        end
        @(posedge clk);
        #1;
        cyc++;
        mem_drive();
    endtask

    task automatic do_reset();
        asrst_n = 1'b0;
        mq.delete();
        cyc    = 0;
        hs_cnt = 0;
        mem_drive();
        @(posedge clk);
        #1;
        asrst_n = 1'b1;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        lat      = 1;
        cyc      = 0;
        hs_cnt   = 0;
        asrst_n  = 1'b0;
        hold     = 1'b0;
        jmp_vld  = 1'b0;
        jmp_addr = 32'h0;
        imem_bus.imem_req_rdy  = 1'b1;
        imem_bus.imem_rsp_vld  = 1'b0;
        imem_bus.imem_rsp_data = 32'h0;
        #2;
        chk("rst_req_vld",  32'(imem_bus.imem_req_vld), 32'd0);
        chk("rst_if_vld",   32'(IF_vld),   32'd0);
        chk("rst_if_pc",    IF_pc,         32'h0);
        chk("rst_if_inst",  IF_inst,       32'h0000_0013);
        chk("rst_if_level", 32'(IF_level), 32'd0);

        // Streaming with 1-cycle memory, no stall
        lat = 1; hold = 1'b0;
        do_reset();
        #1;
        chk("t1_req_vld",   32'(imem_bus.imem_req_vld), 32'd1);
        chk("t1_req_addr0", imem_bus.imem_req_addr, 32'h0);
        cycle();
        chk("t1_if_empty",  32'(IF_vld), 32'd0);
        chk("t1_req_addr4", imem_bus.imem_req_addr, 32'h4);
        cycle();
        chk("t1_if_vld",    32'(IF_vld), 32'd1);
        chk("t1_if_pc0",    IF_pc,   32'h0);
        chk("t1_if_inst0",  IF_inst, inst_of(32'h0));
        for (int k = 1; k <= 3; k++) begin
            cycle();
            chk("t1_if_pc",   IF_pc,   32'(4 * k));
            chk("t1_if_inst", IF_inst, inst_of(32'(4 * k)));
        end

        // Continuous hold fills the FIFO and exhausts credits
        lat = 1; hold = 1'b1;
        do_reset();
        repeat (8) cycle();
        chk("t2_hs_cnt",    32'(hs_cnt),   32'd4);
        chk("t2_level",     32'(IF_level), 32'd4);
        chk("t2_req_vld",   32'(imem_bus.imem_req_vld), 32'd0);
        chk("t2_head_pc",   IF_pc, 32'h0);
        hold = 1'b0;
        cycle();
        chk("t2_pop_pc4",   IF_pc, 32'h4);
        chk("t2_level3",    32'(IF_level), 32'd3);
        chk("t2_resume_vld",  32'(imem_bus.imem_req_vld), 32'd1);
        chk("t2_resume_addr", imem_bus.imem_req_addr, 32'h10);
        cycle();
        chk("t2_pop_pc8",   IF_pc, 32'h8);
        cycle();
        chk("t2_pop_pcC",   IF_pc, 32'hC);
        cycle();
        chk("t2_pc10",      IF_pc,   32'h10);
        chk("t2_inst10",    IF_inst, inst_of(32'h10));

        // Jump with two requests in flight on a 3-cycle memory
        lat = 3; hold = 1'b0;
        do_reset();
        cycle();
        cycle();
        jmp_vld = 1'b1; jmp_addr = 32'h100;
        #1;
        chk("t3_jmp_no_req", 32'(imem_bus.imem_req_vld), 32'd0);
        cycle();
        jmp_vld = 1'b0;
        #1;
        chk("t3_tgt_addr",  imem_bus.imem_req_addr, 32'h100);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t3_squashed", 32'(IF_vld), 32'd0);
        end
        cycle();
        chk("t3_if_vld",    32'(IF_vld), 32'd1);
        chk("t3_if_pc",     IF_pc,   32'h100);
        chk("t3_if_inst",   IF_inst, inst_of(32'h100));
        chk("t3_level",     32'(IF_level), 32'd1);

        // Jump coincident with a response while decode holds
        lat = 2; hold = 1'b1;
        do_reset();
        cycle();
        cycle();
        cycle();
        chk("t4_pre_vld",   32'(IF_vld), 32'd1);
        chk("t4_pre_pc",    IF_pc, 32'h0);
        jmp_vld = 1'b1; jmp_addr = 32'h203;
        #1;
        chk("t4_jmp_no_req", 32'(imem_bus.imem_req_vld), 32'd0);
        cycle();
        jmp_vld = 1'b0;
        chk("t4_flush_vld",   32'(IF_vld),   32'd0);
        chk("t4_flush_level", 32'(IF_level), 32'd0);
        #1;
        chk("t4_req_vld",   32'(imem_bus.imem_req_vld), 32'd1);
        chk("t4_req_addr",  imem_bus.imem_req_addr, 32'h200);
        cycle();
        chk("t4_drop_a",    32'(IF_vld), 32'd0);
        cycle();
        chk("t4_drop_b",    32'(IF_vld), 32'd0);
        cycle();
        chk("t4_if_vld",    32'(IF_vld), 32'd1);
        chk("t4_if_pc",     IF_pc,   32'h200);
        chk("t4_if_inst",   IF_inst, inst_of(32'h200));
        cycle();
        chk("t4_hold_pc",   IF_pc, 32'h200);
        chk("t4_level2",    32'(IF_level), 32'd2);

        // Jump to the last word: fetch address wraps to zero
        lat = 1; hold = 1'b0;
        do_reset();
        jmp_vld = 1'b1; jmp_addr = 32'hFFFF_FFFC;
        #1;
        chk("t5_jmp_no_req", 32'(imem_bus.imem_req_vld), 32'd0);
        cycle();
        jmp_vld = 1'b0;
        #1;
        chk("t5_addr_top",  imem_bus.imem_req_addr, 32'hFFFF_FFFC);
        cycle();
        chk("t5_addr_wrap", imem_bus.imem_req_addr, 32'h0);
        cycle();
        chk("t5_if_pc_top", IF_pc, 32'hFFFF_FFFC);
        cycle();
        chk("t5_if_pc_0",   IF_pc, 32'h0);

        // Asynchronous reset in the middle of a burst, no clock edge
        asrst_n = 1'b0;
        #1;
        chk("t6_req_vld",   32'(imem_bus.imem_req_vld), 32'd0);
        chk("t6_if_vld",    32'(IF_vld),   32'd0);
        chk("t6_if_inst",   IF_inst,       32'h0000_0013);
        chk("t6_if_pc",     IF_pc,         32'h0);
        chk("t6_if_level",  32'(IF_level), 32'd0);
        do_reset();
        #1;
        chk("t6_req_vld_rel", 32'(imem_bus.imem_req_vld), 32'd1);
        chk("t6_req_addr",  imem_bus.imem_req_addr, 32'h0);
        cycle();
        cycle();
        chk("t6_if_pc",     IF_pc, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_prefetch_buf.md
Name: inst_prefetch_buf

Overview:
Parametrised instruction-fetch front end for the next-generation RV32 core. It replaces the single-cycle fetch path with a decoupled request/response instruction-memory port that supports variable latency. Fetched instructions are held in a DEPTH-entry in-order prefetch FIFO that feeds decode. Jumps redirect the fetch PC, flush the FIFO, and squash any responses still in flight.

Parameters:
DEPTH, 4, prefetch FIFO entries and maximum outstanding requests; power of 2, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INST, 32'h0000_0013, value driven on IF_inst when the FIFO is empty (addi x0,x0,0)

Ports:
clk  in  1  core clock
asrst_n  in  1  asynchronous active-low reset
hold  in  1  decode stall; head entry is not consumed
jmp_vld  in  1  redirect request (from Control)
jmp_addr  in  32  redirect target; bits [1:0] ignored and treated as 0
imem_req_vld  out  1  fetch request valid
imem_req_rdy  in  1  memory accepts the request
imem_req_addr  out  32  fetch address, word aligned
imem_rsp_vld  in  1  in-order response valid; always accepted
imem_rsp_data  in  32  fetched instruction
IF_vld  out  1  head entry valid
IF_pc  out  32  PC of the head entry
IF_inst  out  32  instruction of the head entry
IF_level  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0. Outputs during and after reset: imem_req_vld=0 during reset, IF_vld=0, IF_pc=0, IF_inst=NOP_INST, IF_level=0.
- Credit rule: imem_req_vld = !jmp_vld && (outstanding + IF_level < DEPTH). imem_req_addr = fetch_pc.
- Request handshake (imem_req_vld && imem_req_rdy): fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0), outstanding++.
- Each request's PC is pushed into an internal PC queue of DEPTH entries at handshake. It is popped on the response and paired with the instruction in the FIFO entry.
- Response while drop_cnt==0: push {pc, imem_rsp_data} into the FIFO, outstanding--.
- Response while drop_cnt>0: discard it and pop its PC, drop_cnt--, outstanding--.
- Outstanding counter: simultaneous handshake and response leave it unchanged.
- Output is show-ahead: IF_vld = FIFO not empty; IF_pc/IF_inst = head entry, or 0/NOP_INST when empty.
- Pop: when IF_vld && !hold && !jmp_vld.
- Push and pop in the same cycle: IF_level unchanged. The credit rule guarantees push never occurs when full.
- Empty FIFO with a response arriving: the entry appears on IF_* the next cycle. There is no bypass; minimum fetch-to-IF latency is memory latency + 1.
- Jump, in the cycle jmp_vld=1:
  - FIFO cleared; IF_vld=0 next cycle.
  - fetch_pc <= {jmp_addr[31:2],2'b00}.
  - No request is issued.
  - drop_cnt <= outstanding - (imem_rsp_vld ? 1 : 0). A response arriving in the jump cycle is discarded.
  - If drop_cnt was already >0, the same formula applies and all in-flight responses are squashed.
  - The first request to the target issues the next cycle, subject to the credit rule.
- Jump with hold=1: the jump wins; the FIFO is flushed regardless of hold.
- Consecutive jumps: the last one wins; the drop count always covers every outstanding request.
- Reset mid-operation: all state is cleared immediately. Responses for pre-reset requests are not expected; the memory must also be reset.
- Counter widths: outstanding, drop_cnt and IF_level are clog2(DEPTH)+1 bits; none can exceed DEPTH.

Test Plan:
- Reset release, memory always ready with 1-cycle latency, hold=0 -> requests at 0x0,0x4,0x8…; IF_pc 0x0 first appears 2 cycles after the first handshake, then one instruction per cycle.
- DEPTH=4, hold=1 continuously -> exactly 4 requests issued, IF_level=4, imem_req_vld=0; release hold -> IF_pc 0x0..0xC pop in order and requests resume.
- Memory latency 3, two requests in flight, jmp_vld with jmp_addr=0x100 -> both old responses discarded, FIFO empty; next IF_pc=0x100 with its instruction.
- Jump in the same cycle as a response arrives, hold=1 -> response dropped, FIFO flushed, drop_cnt = outstanding-1, first post-jump IF_pc=jmp_addr.
- jmp_addr=0x103 -> imem_req_addr=0x100. Jump to 0xFFFF_FFFC -> next request address is 0x0000_0000.
- Assert asrst_n low mid-burst with no clock edge -> imem_req_vld=0, IF_vld=0, IF_inst=0x0000_0013 immediately; after release the first request is RESET_PC.
